// File: rtl/seq_mul_div_if.sv
// Start/done handshake bundle for the sequential multiply/divide unit.
// The master drives the operands and start; the slave returns status and results.
interface seq_mul_div_if #(
  parameter int unsigned N = 8
) ();
  logic         start;
  logic         op_div;
  logic         is_signed;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] res_lo;
  logic [N-1:0] res_hi;
  logic         div_by_zero;

  modport master (
    output start, op_div, is_signed, a, b,
    input  busy, done, res_lo, res_hi, div_by_zero
  );

  modport slave (
    input  start, op_div, is_signed, a, b,
    output busy, done, res_lo, res_hi, div_by_zero
  );
endinterface

// File: rtl/seq_mul_div.sv
// Multi-cycle shift-add multiplier / restoring divider over one shared N-bit datapath.
// Operands are taken as magnitudes; the sign fix-up happens in the single FIX cycle.
module seq_mul_div #(
  parameter int unsigned N = 8
) (
  input logic         clk,
  input logic         rst,
  seq_mul_div_if.slave bus
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e         state_q;
  logic           op_div_q, neg_res_q, neg_rem_q, dbz_q;
  logic [N:0]     acc_q;
  logic [N-1:0]   lo_q;
  logic [N-1:0]   opb_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q, done_q, dbz_out_q;
  logic [N-1:0]   res_lo_q, res_hi_q;

  logic [N:0]     acc_d;
  logic [N-1:0]   lo_d;
  logic [N-1:0]   abs_a, abs_b, addend;
  logic [N:0]     mul_sum, rem_sh, trial;
  logic [2*N-1:0] prod, prod_fix;
  logic [N-1:0]   quot_fix, rem_fix;

  always_comb begin
    abs_a   = (bus.is_signed && bus.a[N-1]) ? -bus.a : bus.a;
    abs_b   = (bus.is_signed && bus.b[N-1]) ? -bus.b : bus.b;
    addend  = lo_q[0] ? opb_q : '0;
    mul_sum = acc_q + {1'b0, addend};
    // Remainder is always below the divisor, so N+1 bits keep the borrow in the MSB.
    rem_sh  = {acc_q[N-1:0], lo_q[N-1]};
    trial   = rem_sh - {1'b0, opb_q};
    if (op_div_q) begin
      if (!trial[N]) begin
        acc_d = trial;
        lo_d  = {lo_q[N-2:0], 1'b1};
      end else begin
        acc_d = rem_sh;
        lo_d  = {lo_q[N-2:0], 1'b0};
      end
    end else begin
      acc_d = {1'b0, mul_sum[N:1]};
      lo_d  = {mul_sum[0], lo_q[N-1:1]};
    end
    prod     = {acc_q[N-1:0], lo_q};
    prod_fix = neg_res_q ? -prod : prod;
    quot_fix = neg_res_q ? -lo_q : lo_q;
    rem_fix  = neg_rem_q ? -acc_q[N-1:0] : acc_q[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      acc_q     <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_div_q  <= bus.op_div;
            neg_res_q <= bus.is_signed & (bus.a[N-1] ^ bus.b[N-1]);
            neg_rem_q <= bus.is_signed & bus.a[N-1];
            busy_q    <= 1'b1;
            cnt_q     <= CW'(N);
            acc_q     <= '0;
            if (bus.op_div && (bus.b == '0)) begin
              // Keep the raw dividend for the divide-by-zero result.
              dbz_q   <= 1'b1;
              lo_q    <= bus.a;
              opb_q   <= '0;
              state_q <= StFix;
            end else begin
              dbz_q   <= 1'b0;
              state_q <= StCalc;
              if (bus.op_div) begin
                lo_q  <= abs_a;
                opb_q <= abs_b;
              end else begin
                lo_q  <= abs_b;
                opb_q <= abs_a;
              end
            end
          end
        end
        StCalc: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          if (dbz_q) begin
            res_lo_q  <= '1;
            res_hi_q  <= lo_q;
            dbz_out_q <= 1'b1;
          end else if (op_div_q) begin
            res_lo_q  <= quot_fix;
            res_hi_q  <= rem_fix;
            dbz_out_q <= 1'b0;
          end else begin
            res_lo_q  <= prod_fix[N-1:0];
            res_hi_q  <= prod_fix[2*N-1:N];
            dbz_out_q <= 1'b0;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.res_lo      = res_lo_q;
  assign bus.res_hi      = res_hi_q;
  assign bus.div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_seq_mul_div.sv
// Scoreboard bench for seq_mul_div at N=8 and N=32: stimulus pushes model results,
// per-instance monitors pop and compare on every done pulse.
module tb_seq_mul_div;

  typedef struct {
    logic [63:0] lo;
    logic [63:0] hi;
    bit          dbz;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t q8[$];
  exp_t q32[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mul_div_if #(.N(8))  if8 ();
  seq_mul_div_if #(.N(32)) if32 ();

  seq_mul_div #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  seq_mul_div #(.N(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Reference: plain integer arithmetic on sign-extended values.
  function automatic void model(input int w, input bit op, input bit sgn,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] lo, output logic [63:0] hi,
                                output bit dz);
    logic [63:0] mask;
    longint      sa, sb, p, q, r;
    mask = (64'd1 << w) - 64'd1;
    sa   = (sgn && a[w-1]) ? longint'(a | ~mask) : longint'(a & mask);
    sb   = (sgn && b[w-1]) ? longint'(b | ~mask) : longint'(b & mask);
    dz   = 1'b0;
    if (!op) begin
      p  = sa * sb;
      lo = p & mask;
      hi = (p >> w) & mask;
    end else if ((b & mask) == 64'd0) begin
      lo = mask;
      hi = a & mask;
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q & mask;
      hi = r & mask;
    end
  endfunction

  task automatic issue(input int w, input bit op, input bit sgn,
                       input logic [63:0] a, input logic [63:0] b);
    exp_t        e;
    int          n;
    logic [63:0] lo, hi;
    bit          dz;
    n = 0;
    @(negedge clk);
    while (((w == 8) ? if8.busy : if32.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("issue_wait_idle");
    model(w, op, sgn, a, b, lo, hi, dz);
    e.lo  = lo;
    e.hi  = hi;
    e.dbz = dz;
    e.cyc = cyc + 1 + (dz ? 1 : w + 1);
    if (w == 8) begin
      if8.start = 1'b1; if8.op_div = op; if8.is_signed = sgn;
      if8.a = a[7:0]; if8.b = b[7:0];
      q8.push_back(e);
    end else begin
      if32.start = 1'b1; if32.op_div = op; if32.is_signed = sgn;
      if32.a = a[31:0]; if32.b = b[31:0];
      q32.push_back(e);
    end
    @(posedge clk);
    #1;
    if (w == 8) if8.start = 1'b0;
    else        if32.start = 1'b0;
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst && if8.done) begin
      if (q8.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL n8_unexpected_done at cycle %0d", cyc);
      end else begin
        e = q8.pop_front();
        chk("n8_res_lo", 64'(if8.res_lo), e.lo);
        chk("n8_res_hi", 64'(if8.res_hi), e.hi);
        chk("n8_div_by_zero", 64'(if8.div_by_zero), 64'(e.dbz));
        chk("n8_latency", 64'(cyc), 64'(e.cyc));
        chk("n8_busy_at_done", 64'(if8.busy), 64'd0);
      end
    end
  end

  always @(negedge clk) begin : mon32
    exp_t e;
    if (!rst && if32.done) begin
      if (q32.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL n32_unexpected_done at cycle %0d", cyc);
      end else begin
        e = q32.pop_front();
        chk("n32_res_lo", 64'(if32.res_lo), e.lo);
        chk("n32_res_hi", 64'(if32.res_hi), e.hi);
        chk("n32_div_by_zero", 64'(if32.div_by_zero), 64'(e.dbz));
        chk("n32_latency", 64'(cyc), 64'(e.cyc));
        chk("n32_busy_at_done", 64'(if32.busy), 64'd0);
      end
    end
  end

  initial begin
    exp_t        drop;
    int          cnt;
    logic [63:0] a, b, mask;
    int          w;
    if8.start  = 1'b0; if8.op_div  = 1'b0; if8.is_signed  = 1'b0; if8.a  = '0; if8.b  = '0;
    if32.start = 1'b0; if32.op_div = 1'b0; if32.is_signed = 1'b0; if32.a = '0; if32.b = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(if8.busy), 64'd0);
    chk("rst_done", 64'(if8.done), 64'd0);
    chk("rst_res_lo", 64'(if8.res_lo), 64'd0);
    chk("rst_res_hi", 64'(if8.res_hi), 64'd0);
    chk("rst_dbz", 64'(if8.div_by_zero), 64'd0);
    chk("rst_busy32", 64'(if32.busy), 64'd0);
    rst = 1'b0;

    // Directed vectors.
    issue(8, 1'b0, 1'b0, 64'd200, 64'd150);
    cnt = 0;
    @(negedge clk);
    while (if8.busy && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("n8_busy_cycles", 64'(cnt), 64'd9);
    issue(8, 1'b0, 1'b1, 64'hFD, 64'h05);
    issue(8, 1'b0, 1'b1, 64'h80, 64'h80);
    issue(8, 1'b1, 1'b1, 64'hF9, 64'h02);
    issue(8, 1'b1, 1'b0, 64'hF9, 64'h02);
    issue(8, 1'b1, 1'b0, 64'hC8, 64'h00);
    issue(8, 1'b1, 1'b1, 64'h80, 64'hFF);

    // Start and operand changes while busy must be ignored.
    issue(8, 1'b0, 1'b0, 64'd13, 64'd11);
    repeat (3) begin
      @(negedge clk);
      if8.start = 1'b1; if8.op_div = 1'b1; if8.a = 8'hFF; if8.b = 8'h03;
    end
    @(negedge clk);
    if8.start = 1'b0;

    // Reset in the middle of a multiply: no done, everything cleared.
    issue(8, 1'b0, 1'b0, 64'd77, 64'd99);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drop = q8.pop_back();
    chk("midrst_busy", 64'(if8.busy), 64'd0);
    chk("midrst_done", 64'(if8.done), 64'd0);
    chk("midrst_res_lo", 64'(if8.res_lo), 64'd0);
    chk("midrst_res_hi", 64'(if8.res_hi), 64'd0);
    chk("midrst_dbz", 64'(if8.div_by_zero), 64'd0);

    // Reset and start together: start is dropped.
    @(negedge clk);
    rst = 1'b1;
    if8.start = 1'b1; if8.op_div = 1'b0; if8.a = 8'd5; if8.b = 8'd6;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if8.start = 1'b0;
    chk("rst_start_busy", 64'(if8.busy), 64'd0);
    repeat (12) @(negedge clk);
    chk("rst_start_idle", 64'(if8.busy), 64'd0);
    issue(8, 1'b0, 1'b0, 64'd100, 64'd3);

    // Random regression, all four modes, both widths.
    for (int pass = 0; pass < 2; pass++) begin
      w    = (pass == 0) ? 8 : 32;
      mask = (64'd1 << w) - 64'd1;
      for (int i = 0; i < ((w == 8) ? 160 : 80); i++) begin
        a = {32'($urandom), 32'($urandom)} & mask;
        b = {32'($urandom), 32'($urandom)} & mask;
        case ($urandom_range(0, 7))
          0: b = 64'd0;
          1: begin a = 64'd1 << (w - 1); b = mask; end
          2: b = 64'd1;
          3: a = 64'd0;
          default: ;
        endcase
        issue(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b);
      end
    end

    cnt = 0;
    while ((q8.size() != 0 || q32.size() != 0) && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 500) timeout("drain_scoreboard");
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
